// File: rtl/llrf_sync_gen.sv
// Periodic DDS sync-pulse generator: free-runs at a programmable period,
// re-phases on timing-system events and tracks phase lock.
module llrf_sync_gen #(
    parameter int CW          = 16,
    parameter int DEFAULT_PRD = 10,
    parameter int LOCK_CNT    = 4,
    parameter int TOL         = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [CW-1:0] prd,
    input  logic          prd_wr,
    input  logic          sync_ev_p,
    output logic          sync,
    output logic [CW-1:0] phase_err,
    output logic          phase_err_vld,
    output logic          locked,
    output logic [7:0]    realign_cnt
);

    localparam int LW = $clog2(LOCK_CNT + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] prd_act;
    logic [CW-1:0] prd_shadow;
    logic          pend;
    logic [LW-1:0] lock_cnt;

    logic [CW-1:0] prd_clamp;
    logic [CW-1:0] shadow_nxt;
    logic          pend_nxt;
    logic          wrap;
    logic          boundary;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] pe_calc;
    logic          in_tol;

    always_comb begin
        prd_clamp  = (prd < CW'(2)) ? CW'(2) : prd;
        // A write in the boundary cycle itself must be the value applied there.
        shadow_nxt = prd_wr ? prd_clamp : prd_shadow;
        pend_nxt   = pend | prd_wr;
        wrap       = (cnt == prd_act - CW'(1));
        boundary   = wrap | sync_ev_p;
        cnt_inc    = cnt + CW'(1);
        pe_calc    = (cnt_inc == prd_act) ? '0 : cnt_inc;
        in_tol     = (pe_calc <= CW'(TOL)) || (pe_calc >= prd_act - CW'(TOL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            prd_act       <= CW'(DEFAULT_PRD);
            prd_shadow    <= CW'(DEFAULT_PRD);
            pend          <= 1'b0;
            lock_cnt      <= '0;
            sync          <= 1'b0;
            phase_err     <= '0;
            phase_err_vld <= 1'b0;
            locked        <= 1'b0;
            realign_cnt   <= '0;
        end else begin
            sync          <= 1'b0;
            phase_err_vld <= 1'b0;
            prd_shadow    <= shadow_nxt;
            pend          <= pend_nxt;
            if (!ena) begin
                cnt      <= '0;
                locked   <= 1'b0;
                lock_cnt <= '0;
                if (pend_nxt) begin
                    prd_act <= shadow_nxt;
                    pend    <= 1'b0;
                end
            end else begin
                if (boundary) begin
                    cnt  <= '0;
                    sync <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                end
                if (sync_ev_p) begin
                    phase_err     <= pe_calc;
                    phase_err_vld <= 1'b1;
                    if (in_tol) begin
                        if (lock_cnt != LW'(LOCK_CNT))
                            lock_cnt <= lock_cnt + LW'(1);
                        locked <= (lock_cnt >= LW'(LOCK_CNT - 1));
                    end else begin
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                        if (realign_cnt != '1)
                            realign_cnt <= realign_cnt + 8'd1;
                    end
                end
                // Period switch overrides any lock gained by a coincident event.
                if (boundary && pend_nxt) begin
                    prd_act  <= shadow_nxt;
                    pend     <= 1'b0;
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_llrf_sync_gen.sv
// Scoreboard bench for llrf_sync_gen: expected sync pulses and event
// reports are queued as stimulus is driven and compared as outputs appear.
module tb_llrf_sync_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic [15:0] prd = '0;
    logic        prd_wr = 1'b0;
    logic        sync_ev_p = 1'b0;
    logic        sync;
    logic [15:0] phase_err;
    logic        phase_err_vld;
    logic        locked;
    logic [7:0]  realign_cnt;

    typedef struct {
        int unsigned cyc;
        logic [15:0] pe;
        logic        lk;
        logic [7:0]  rc;
    } ev_t;

    int unsigned sync_q[$];
    ev_t         ev_q[$];
    int unsigned cyc = 0;
    int unsigned b = 0;
    int          checks = 0;
    int          errors = 0;

    llrf_sync_gen #(.CW(16), .DEFAULT_PRD(10), .LOCK_CNT(4), .TOL(0)) dut (
        .clk(clk), .rst(rst), .ena(ena), .prd(prd), .prd_wr(prd_wr),
        .sync_ev_p(sync_ev_p), .sync(sync), .phase_err(phase_err),
        .phase_err_vld(phase_err_vld), .locked(locked), .realign_cnt(realign_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (sync === 1'b1) begin
            checks++;
            if (sync_q.size() == 0) begin
                errors++;
                $display("FAIL sync_unexpected at cycle %0d", cyc);
            end else begin
                int unsigned e;
                e = sync_q.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL sync_time got cycle %0d expected %0d", cyc, e);
                end
            end
        end
        if (phase_err_vld === 1'b1) begin
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $display("FAIL vld_unexpected at cycle %0d", cyc);
            end else begin
                ev_t r;
                r = ev_q.pop_front();
                if (cyc !== r.cyc || phase_err !== r.pe || locked !== r.lk || realign_cnt !== r.rc) begin
                    errors++;
                    $display("FAIL event got cyc=%0d pe=%0d lk=%0b rc=%0d expected cyc=%0d pe=%0d lk=%0b rc=%0d",
                             cyc, phase_err, locked, realign_cnt, r.cyc, r.pe, r.lk, r.rc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_until(input int unsigned e);
        if (cyc > e - 1) begin
            errors++;
            $display("FAIL schedule cycle %0d already past %0d", cyc, e - 1);
        end
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic enable();
        rst = 1'b0;
        ena = 1'b1;
        b   = cyc;
    endtask

    task automatic disable_before(input int unsigned e);
        wait_until(e);
        ena = 1'b0;
    endtask

    task automatic event_at(input int unsigned c, input logic [15:0] pe,
                            input logic lk, input logic [7:0] rc);
        int unsigned f;
        ev_t r;
        f = b + 1 + c;
        wait_until(f);
        sync_ev_p = 1'b1;
        sync_q.push_back(f);
        r.cyc = f; r.pe = pe; r.lk = lk; r.rc = rc;
        ev_q.push_back(r);
        tick();
        sync_ev_p = 1'b0;
        b = f;
    endtask

    task automatic write_prd(input logic [15:0] v);
        prd    = v;
        prd_wr = 1'b1;
        tick();
        prd_wr = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (sync_q.size() > 0 || ev_q.size() > 0); i++) tick();
        checks++;
        if (sync_q.size() != 0 || ev_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending sync=%0d events=%0d expected 0 0", name, sync_q.size(), ev_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (5) tick();
        checks++;
        if ({sync, phase_err_vld, locked} !== 3'b000 || phase_err !== 16'd0 || realign_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs got sync=%0b vld=%0b lk=%0b pe=%0d rc=%0d expected all 0",
                     sync, phase_err_vld, locked, phase_err, realign_cnt);
        end
        enable();
        sync_q.push_back(b + 10);
        sync_q.push_back(b + 20);
        sync_q.push_back(b + 30);
        disable_before(b + 31);
        drain("reset");
    endtask

    task automatic test_misaligned();
        enable();
        event_at(2, 16'd3, 1'b0, 8'd1);
        sync_q.push_back(b + 10);
        disable_before(b + 11);
        drain("misaligned");
    endtask

    task automatic test_lock();
        enable();
        event_at(9, 16'd0, 1'b0, 8'd1);
        event_at(9, 16'd0, 1'b0, 8'd1);
        event_at(9, 16'd0, 1'b0, 8'd1);
        event_at(9, 16'd0, 1'b1, 8'd1);
        event_at(5, 16'd6, 1'b0, 8'd2);
        disable_before(b + 1);
        drain("lock");
    endtask

    task automatic test_period_change();
        enable();
        for (int i = 0; i < 4; i++) event_at(9, 16'd0, (i == 3), 8'd2);
        wait_until(b + 5);
        write_prd(16'd16);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_before_switch got %0b expected 1", locked);
        end
        sync_q.push_back(b + 10);
        sync_q.push_back(b + 26);
        sync_q.push_back(b + 42);
        wait_until(b + 11);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_after_switch got %0b expected 0", locked);
        end
        wait_until(b + 43);
        write_prd(16'd1);
        sync_q.push_back(b + 58);
        sync_q.push_back(b + 60);
        sync_q.push_back(b + 62);
        disable_before(b + 63);
        drain("period");
    endtask

    task automatic test_enable();
        tick();
        write_prd(16'd10);
        sync_ev_p = 1'b1;
        tick();
        sync_ev_p = 1'b0;
        tick();
        checks++;
        if (realign_cnt !== 8'd2 || locked !== 1'b0 || sync !== 1'b0) begin
            errors++;
            $display("FAIL disabled_event got rc=%0d lk=%0b sync=%0b expected 2 0 0", realign_cnt, locked, sync);
        end
        enable();
        sync_q.push_back(b + 10);
        disable_before(b + 14);
        tick();
        sync_ev_p = 1'b1;
        tick();
        sync_ev_p = 1'b0;
        repeat (3) tick();
        checks++;
        if (realign_cnt !== 8'd2 || locked !== 1'b0 || sync !== 1'b0 || phase_err_vld !== 1'b0) begin
            errors++;
            $display("FAIL midperiod_disable got rc=%0d lk=%0b sync=%0b vld=%0b expected 2 0 0 0",
                     realign_cnt, locked, sync, phase_err_vld);
        end
        enable();
        sync_q.push_back(b + 10);
        disable_before(b + 11);
        drain("enable");
    endtask

    task automatic test_saturation_reset();
        int unsigned rc;
        enable();
        for (int k = 0; k < 300; k++) begin
            rc = (k + 3 > 255) ? 255 : k + 3;
            event_at(2, 16'd3, 1'b0, 8'(rc));
        end
        checks++;
        if (realign_cnt !== 8'd255) begin
            errors++;
            $display("FAIL realign_saturate got %0d expected 255", realign_cnt);
        end
        wait_until(b + 3);
        write_prd(16'd20);
        wait_until(b + 6);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (realign_cnt !== 8'd0 || locked !== 1'b0 || phase_err !== 16'd0 || sync !== 1'b0) begin
            errors++;
            $display("FAIL midperiod_reset got rc=%0d lk=%0b pe=%0d sync=%0b expected 0 0 0 0",
                     realign_cnt, locked, phase_err, sync);
        end
        enable();
        sync_q.push_back(b + 10);
        sync_q.push_back(b + 20);
        disable_before(b + 21);
        drain("reset_discard");
    endtask

    initial begin
        tick();
        test_reset();
        test_misaligned();
        test_lock();
        test_period_change();
        test_enable();
        test_saturation_reset();
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
